// File: rtl/mul_stream_seq_pkg.sv
// Shared types and constants for the byte-stream multiplier front/back end.
package mul_stream_seq_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = 2;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        StLoad,
        StSettle,
        StSend
    } state_e;

endpackage

// File: rtl/mul_stream_seq_ser.sv
// 32-bit to 8-bit serializer with valid/ready handshake, least significant byte first.
module mul_stream_seq_ser
    import mul_stream_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        done
);

    logic [31:0] word_q, word_d;
    idx_t        idx_q, idx_d;
    logic        valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done    = 1'b0;
        if (load) begin
            word_d  = word;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            if (idx_q == idx_t'(BYTES_PER_WORD - 1)) begin
                idx_d   = '0;
                valid_d = 1'b0;
                done    = 1'b1;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = word_q[{idx_q, 3'b000} +: 8];

endmodule

// File: rtl/mul_stream_seq.sv
// Byte-stream operand loader and result serializer around a combinational 16x16 multiplier.
// Optional running accumulator enabled by defining MUL_STREAM_SEQ_ACC_EN.
module mul_stream_seq
    import mul_stream_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [31:0] mul_in,
    input  logic [31:0] mul_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    input  logic        acc_clr,
    output logic        busy
);

    state_e      state_q, state_d;
    idx_t        idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] mul_in_q, mul_in_d;
    logic        capture;
    logic [31:0] result;
    logic        ser_done;

`ifdef MUL_STREAM_SEQ_ACC_EN
    logic [31:0] acc_q, acc_d;

    // Clear takes effect before the add when both happen in one cycle.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end
        if (capture) begin
            acc_d = acc_d + mul_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result = acc_d;
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
    assign result         = mul_out;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        mul_in_d = mul_in_q;
        capture  = 1'b0;
        case (state_q)
            StLoad: begin
                if (in_valid) begin
                    mul_in_d[{idx_q, 3'b000} +: 8] = in_data;
                    if (idx_q == idx_t'(BYTES_PER_WORD - 1)) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = StSettle;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (ser_done) begin
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StLoad;
            idx_q    <= '0;
            cnt_q    <= '0;
            mul_in_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            mul_in_q <= mul_in_d;
        end
    end

    mul_stream_seq_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .word      (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (ser_done)
    );

    assign in_ready = (state_q == StLoad);
    assign busy     = (state_q != StLoad);
    assign mul_in   = mul_in_q;

endmodule

// File: tb/tb_mul_stream_seq.sv
// Self-checking bench: three instances (settle 2, 1, 255) with a multiplier model on mul_in/mul_out,
// checked every cycle against a queue-based reference model plus literal transaction results.
module tb_mul_stream_seq;

    localparam int unsigned SC [3] = '{2, 1, 255};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [7:0]  in_data   [3];
    logic [31:0] mul_in    [3];
    logic [31:0] mul_out   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [7:0]  out_data  [3];
    logic        acc_clr   [3];
    logic        busy      [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        mul_stream_seq #(.SETTLE_CYCLES(SC[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .mul_in    (mul_in[g]),
            .mul_out   (mul_out[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .acc_clr   (acc_clr[g]),
            .busy      (busy[g])
        );
        assign mul_out[g] = {16'h0, mul_in[g][15:0]} * {16'h0, mul_in[g][31:16]};
    end

    task automatic chk(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h (cycle %0d)", name, g, act, exp, cyc);
        end
    endtask

    // Reference model: operand word, settle countdown, queue of pending result bytes.
    logic [31:0] m_word [3];
    logic [31:0] m_acc  [3];
    int          m_idx  [3];
    int          m_wait [3];
    logic [7:0]  m_q    [3][$];

    always @(negedge clk) begin
        bit          rdy, vld, cap;
        logic [31:0] prod;
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                m_word[g] = '0;
                m_acc[g]  = '0;
                m_idx[g]  = 0;
                m_wait[g] = 0;
                m_q[g].delete();
                chk("rst_out_valid", g, 32'(out_valid[g]), 32'd0);
                chk("rst_out_data", g, 32'(out_data[g]), 32'd0);
                chk("rst_busy", g, 32'(busy[g]), 32'd0);
                chk("rst_mul_in", g, mul_in[g], 32'd0);
            end else begin
                rdy = (m_wait[g] == 0) && (m_q[g].size() == 0);
                vld = (m_q[g].size() > 0);
                cap = 1'b0;
                chk("in_ready", g, 32'(in_ready[g]), 32'(rdy));
                chk("out_valid", g, 32'(out_valid[g]), 32'(vld));
                chk("busy", g, 32'(busy[g]), 32'(!rdy));
                chk("mul_in", g, mul_in[g], m_word[g]);
                if (vld) chk("out_data", g, 32'(out_data[g]), 32'(m_q[g][0]));
                if (rdy && in_valid[g]) begin
                    m_word[g][8*m_idx[g] +: 8] = in_data[g];
                    if (m_idx[g] == 3) begin
                        m_idx[g]  = 0;
                        m_wait[g] = int'(SC[g]);
                    end else begin
                        m_idx[g]++;
                    end
                end else if (m_wait[g] > 0) begin
                    if (m_wait[g] == 1) begin
                        cap  = 1'b1;
                        prod = {16'h0, m_word[g][15:0]} * {16'h0, m_word[g][31:16]};
`ifdef MUL_STREAM_SEQ_ACC_EN
                        m_acc[g] = (acc_clr[g] ? 32'd0 : m_acc[g]) + prod;
                        prod     = m_acc[g];
`endif
                        for (int i = 0; i < 4; i++) m_q[g].push_back(prod[8*i +: 8]);
                    end
                    m_wait[g]--;
                end else if (vld && out_ready[g]) begin
                    void'(m_q[g].pop_front());
                end
                if (acc_clr[g] && !cap) m_acc[g] = '0;
            end
        end
    end

    task automatic pulse_clr(input int g);
        acc_clr[g] = 1'b1;
        @(posedge clk); #1;
        acc_clr[g] = 1'b0;
    endtask

    // Operand word w = {B, A}; bytes go out as w[7:0], w[15:8], w[23:16], w[31:24].
    task automatic send4(input int g, input logic [31:0] w, output int t);
        int n;
        bit got;
        t = -1;
        for (int i = 0; i < 4; i++) begin
            n   = 0;
            got = 1'b0;
            in_valid[g] = 1'b1;
            in_data[g]  = w[8*i +: 8];
            while (!got && n < 300) begin
                @(negedge clk);
                if (in_ready[g]) begin
                    got = 1'b1;
                    t   = cyc;
                end
                @(posedge clk); #1;
                n++;
            end
            if (!got) chk("send_timeout", g, 32'd0, 32'd1);
        end
        in_valid[g] = 1'b0;
    endtask

    task automatic recv(input int g, input int nb, input bit toggle, input bit pulse,
                        output logic [31:0] w, output int first);
        int k, n;
        k     = 0;
        n     = 0;
        w     = '0;
        first = -1;
        out_ready[g] = toggle ? 1'b0 : 1'b1;
        while (k < nb && n < 2000) begin
            @(negedge clk);
            if (out_valid[g] && first < 0) first = cyc;
            if (out_valid[g] && out_ready[g]) begin
                w[8*k +: 8] = out_data[g];
                k++;
            end
            @(posedge clk); #1;
            n++;
            if (toggle) out_ready[g] = ~out_ready[g];
            if (pulse) begin
                in_valid[g] = ~in_valid[g];
                in_data[g]  = 8'($urandom);
            end
        end
        if (k < nb) chk("recv_timeout", g, 32'(k), 32'(nb));
        in_valid[g]  = 1'b0;
        out_ready[g] = 1'b0;
    endtask

    task automatic txn(input int g, input logic [31:0] opw, input bit clr, input bit toggle,
                       input bit pulse, input logic [31:0] expw, input string name);
        int t, f;
        logic [31:0] w;
        if (clr) pulse_clr(g);
        send4(g, opw, t);
        @(negedge clk);
        chk({name, "_held"}, g, mul_in[g], opw);
        chk({name, "_settle_rdy"}, g, 32'(in_ready[g]), 32'd0);
        recv(g, 4, toggle, pulse, w, f);
        chk({name, "_result"}, g, w, expw);
        chk({name, "_latency"}, g, 32'(f - t), SC[g] + 1);
    endtask

    initial begin
        int          t, f;
        logic [31:0] w;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_valid[g]  = 1'b0;
            in_data[g]   = '0;
            out_ready[g] = 1'b0;
            acc_clr[g]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        txn(0, 32'h0005_0003, 1'b1, 1'b0, 1'b0, 32'h0000_000F, "t3x5");
        txn(0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFE_0001, "tff");
        txn(0, 32'h0010_1234, 1'b1, 1'b1, 1'b1, 32'h0001_2340, "tbp");

        // Reset in the middle of SEND, then a clean transaction.
        pulse_clr(0);
        send4(0, 32'h0007_0006, t);
        recv(0, 2, 1'b0, 1'b0, w, f);
        chk("partial_bytes", 0, {16'h0, w[15:0]}, 32'h0000_002A);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("mid_rst_out_data", 0, 32'(out_data[0]), 32'd0);
        chk("mid_rst_busy", 0, 32'(busy[0]), 32'd0);
        chk("mid_rst_mul_in", 0, mul_in[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        txn(0, 32'h0003_0002, 1'b1, 1'b0, 1'b0, 32'h0000_0006, "tpost");

        pulse_clr(0);
        txn(0, 32'h0003_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0006, "tacc1");
`ifdef MUL_STREAM_SEQ_ACC_EN
        txn(0, 32'h0005_0004, 1'b0, 1'b0, 1'b0, 32'h0000_001A, "tacc2");
`else
        txn(0, 32'h0005_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0014, "tacc2");
`endif
        txn(0, 32'h0001_0001, 1'b1, 1'b0, 1'b0, 32'h0000_0001, "tacc3");

        txn(1, 32'h0009_0007, 1'b1, 1'b0, 1'b0, 32'h0000_003F, "ts1");
        txn(2, 32'h0009_0007, 1'b1, 1'b0, 1'b0, 32'h0000_003F, "ts255");

        // Random traffic on instance 0; the per-cycle model does the checking.
        for (int i = 0; i < 2000; i++) begin
            in_valid[0]  = 1'($urandom);
            in_data[0]   = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
            out_ready[0] = 1'($urandom);
            acc_clr[0]   = ($urandom_range(31) == 0);
            @(posedge clk); #1;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        acc_clr[0]   = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
